// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// branch_predict_ctrl : direct-mapped 2-bit BHT + BTB, mispredict redirect/flush
// Rev 1.0
// ============================================================================
module branch_predict_ctrl #(
   parameter int IDX_W = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_f,
   output logic            pred_taken_f,
   output logic [XLEN-1:0] pred_target_f,
   input  logic            valid_e,
   input  logic            stall_e,
   input  logic            is_br_e,
   input  logic            br_taken_e,
   input  logic [XLEN-1:0] pc_e,
   input  logic [XLEN-1:0] br_target_e,
   input  logic            pred_taken_e,
   input  logic [XLEN-1:0] pred_target_e,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush_fd,
   output logic [31:0]     br_count,
   output logic [31:0]     mispred_count
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [1:0]       ctr_q [DEPTH];
   logic [XLEN-1:0]  tgt_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [31:0]      br_count_q, br_count_d;
   logic [31:0]      mispred_count_q, mispred_count_d;

   logic [IDX_W-1:0] idx_f, idx_e;
   logic             res, train, actual_taken, mispredict;
   logic             unused_pc_bits;

   assign idx_f = pc_f[IDX_W+1:2];
   assign idx_e = pc_e[IDX_W+1:2];
   assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0]};

   // Fetch reads the registered tables, so a same-cycle update is seen next cycle.
   assign pred_taken_f  = valid_q[idx_f] & ctr_q[idx_f][1];
   assign pred_target_f = tgt_q[idx_f];

   assign res          = valid_e & ~stall_e & ~rst;
   assign train        = res & is_br_e;
   assign actual_taken = is_br_e & br_taken_e;
   assign mispredict   = res & ((actual_taken != pred_taken_e) |
                                (actual_taken & pred_taken_e & (br_target_e != pred_target_e)));

   assign redirect_valid = mispredict;
   assign flush_fd       = mispredict;
   assign redirect_pc    = actual_taken ? br_target_e : pc_e + XLEN'(4);

   assign br_count      = br_count_q;
   assign mispred_count = mispred_count_q;

   always_comb begin
      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;
      if (train && (br_count_q != 32'hFFFF_FFFF))
         br_count_d = br_count_q + 32'd1;
      if (mispredict && (mispred_count_q != 32'hFFFF_FFFF))
         mispred_count_d = mispred_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            ctr_q[k] <= 2'b01;
            tgt_q[k] <= '0;
         end
         valid_q         <= '0;
         br_count_q      <= '0;
         mispred_count_q <= '0;
      end else begin
         br_count_q      <= br_count_d;
         mispred_count_q <= mispred_count_d;
         if (train) begin
            if (br_taken_e) begin
               if (ctr_q[idx_e] != 2'b11)
                  ctr_q[idx_e] <= ctr_q[idx_e] + 2'b01;
               tgt_q[idx_e]   <= br_target_e;
               valid_q[idx_e] <= 1'b1;
            end else if (ctr_q[idx_e] != 2'b00) begin
               ctr_q[idx_e] <= ctr_q[idx_e] - 2'b01;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_predict_ctrl : directed + randomized checks against a table model
// Rev 1.0
// ============================================================================
module tb_branch_predict_ctrl;

   localparam int IDX_W = 4;
   localparam int XLEN  = 32;
   localparam int DEPTH = 16;
   localparam longint unsigned SAT = 64'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_f;
   logic        pred_taken_f;
   logic [31:0] pred_target_f;
   logic        valid_e, stall_e, is_br_e, br_taken_e, pred_taken_e;
   logic [31:0] pc_e, br_target_e, pred_target_e;
   logic        redirect_valid, flush_fd;
   logic [31:0] redirect_pc, br_count, mispred_count;

   always #5 clk = ~clk;

   branch_predict_ctrl #(.IDX_W(IDX_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .pc_f(pc_f),
      .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
      .valid_e(valid_e), .stall_e(stall_e), .is_br_e(is_br_e), .br_taken_e(br_taken_e),
      .pc_e(pc_e), .br_target_e(br_target_e),
      .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_fd(flush_fd),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: per-entry confidence 0..3, valid flag, target; plain counts.
   int               m_ctr [DEPTH];
   bit               m_vld [DEPTH];
   logic [31:0]      m_tgt [DEPTH];
   longint unsigned  m_br, m_mis;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % DEPTH);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_vld[idx_of(pc)] && (m_ctr[idx_of(pc)] >= 2);
   endfunction

   function automatic bit m_mispredict();
      bit resolves, act;
      resolves = valid_e && !stall_e && !rst;
      act      = is_br_e && br_taken_e;
      return resolves && ((act != pred_taken_e) || (act && (br_target_e != pred_target_e)));
   endfunction

   function automatic logic [31:0] m_rpc();
      return (is_br_e && br_taken_e) ? br_target_e : 32'(pc_e + 32'd4);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < DEPTH; k++) begin
         m_ctr[k] = 1; m_vld[k] = 0; m_tgt[k] = '0;
      end
      m_br = 0; m_mis = 0;
   endtask

   task automatic step();
      bit mis;
      int j;
      @(posedge clk);
      if (rst) model_reset();
      else begin
         mis = m_mispredict();
         if (valid_e && !stall_e && is_br_e) begin
            j = idx_of(pc_e);
            if (m_br < SAT) m_br++;
            if (br_taken_e) begin
               if (m_ctr[j] < 3) m_ctr[j]++;
               m_tgt[j] = br_target_e;
               m_vld[j] = 1;
            end else if (m_ctr[j] > 0) m_ctr[j]--;
         end
         if (mis && m_mis < SAT) m_mis++;
      end
      #1;
   endtask

   task automatic set_e(input bit v, input bit s, input bit b, input bit t,
                        input logic [31:0] pc, input logic [31:0] tg,
                        input bit pt, input logic [31:0] ptg);
      valid_e = v; stall_e = s; is_br_e = b; br_taken_e = t;
      pc_e = pc; br_target_e = tg; pred_taken_e = pt; pred_target_e = ptg;
   endtask

   task automatic idle_e();
      set_e(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
   endtask

   task automatic test_reset();
      rst = 1'b1; pc_f = 32'h40;
      set_e(1, 0, 1, 1, 32'h40, 32'h80, 0, 32'h0);
      #1;
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect: got %b want 0", redirect_valid); end
      checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", flush_fd); end
      step(); step();
      rst = 1'b0; idle_e(); #1;
      checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL rst_br_count: got %h want 0", br_count); end
      checks++; if (mispred_count !== 32'd0) begin errors++; $display("FAIL rst_mispred_count: got %h want 0", mispred_count); end
      for (int k = 0; k < DEPTH; k++) begin
         pc_f = 32'(k * 4); #1;
         checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL rst_pred idx %0d: got %b want 0", k, pred_taken_f); end
      end
   endtask

   task automatic test_train_and_redirect();
      pc_f = 32'h40;
      set_e(1, 0, 1, 1, 32'h40, 32'h80, 0, 32'h0); #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL first_pred: got %b want 0", pred_taken_f); end
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL first_redirect: got %b want 1", redirect_valid); end
      checks++; if (flush_fd !== 1'b1) begin errors++; $display("FAIL first_flush: got %b want 1", flush_fd); end
      checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL first_rpc: got %h want 00000080", redirect_pc); end
      step(); idle_e(); #1;
      checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL trained_pred: got %b want 1", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h80) begin errors++; $display("FAIL trained_tgt: got %h want 00000080", pred_target_f); end
      checks++; if (br_count !== 32'd1) begin errors++; $display("FAIL first_br_count: got %0d want 1", br_count); end
      checks++; if (mispred_count !== 32'd1) begin errors++; $display("FAIL first_mis_count: got %0d want 1", mispred_count); end
      for (int n = 0; n < 3; n++) begin
         set_e(1, 0, 1, 1, 32'h40, 32'h80, 1, 32'h80); #1;
         checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL correct_pred_redirect %0d: got %b want 0", n, redirect_valid); end
         step();
      end
      set_e(1, 0, 1, 0, 32'h40, 32'h1234, 1, 32'h80); #1;
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL nt_redirect: got %b want 1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL nt_rpc: got %h want 00000044", redirect_pc); end
      step(); idle_e(); #1;
      checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL sat_pred (ctr 2): got %b want 1", pred_taken_f); end
      checks++; if (br_count !== 32'd5) begin errors++; $display("FAIL br_count5: got %0d want 5", br_count); end
      checks++; if (mispred_count !== 32'd2) begin errors++; $display("FAIL mis_count2: got %0d want 2", mispred_count); end
      set_e(1, 0, 1, 0, 32'h40, 32'h0, 1, 32'h80); step(); idle_e(); #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL pred_after_2nt (ctr 1): got %b want 0", pred_taken_f); end
      set_e(1, 0, 1, 1, 32'h100, 32'h300, 1, 32'h200); #1;
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL jalr_redirect: got %b want 1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h300) begin errors++; $display("FAIL jalr_rpc: got %h want 00000300", redirect_pc); end
      step(); idle_e(); #1;
      checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL jalr_pred: got %b want 1", pred_taken_f); end
      checks++; if (pred_target_f !== 32'h300) begin errors++; $display("FAIL jalr_tgt: got %h want 00000300", pred_target_f); end
      checks++; if (mispred_count !== 32'd4) begin errors++; $display("FAIL jalr_mis_count: got %0d want 4", mispred_count); end
   endtask

   task automatic test_alias();
      pc_f = 32'h10;
      set_e(1, 0, 0, 0, 32'h10, 32'h999, 1, 32'h50); #1;
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL alias_redirect: got %b want 1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h14) begin errors++; $display("FAIL alias_rpc: got %h want 00000014", redirect_pc); end
      step(); idle_e(); #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL alias_table: got %b want 0", pred_taken_f); end
      checks++; if (br_count !== 32'd7) begin errors++; $display("FAIL alias_br_count: got %0d want 7", br_count); end
      checks++; if (mispred_count !== 32'd5) begin errors++; $display("FAIL alias_mis_count: got %0d want 5", mispred_count); end
      set_e(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h8, 1, 32'h8); #1;
      checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL wrap_rpc: got %h want 00000000", redirect_pc); end
      step(); idle_e();
   endtask

   task automatic test_stall();
      pc_f = 32'h40;
      for (int n = 0; n < 2; n++) begin
         set_e(1, 1, 1, 0, 32'h40, 32'h0, 1, 32'h300); #1;
         checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL stall_redirect %0d: got %b want 0", n, redirect_valid); end
         checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL stall_flush %0d: got %b want 0", n, flush_fd); end
         step();
      end
      stall_e = 1'b0; #1;
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL unstall_redirect: got %b want 1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL unstall_rpc: got %h want 00000044", redirect_pc); end
      checks++; if (pred_taken_f !== 1'b1) begin errors++; $display("FAIL same_idx_old_pred: got %b want 1", pred_taken_f); end
      step(); idle_e(); #1;
      checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL same_idx_new_pred: got %b want 0", pred_taken_f); end
      checks++; if (br_count !== 32'd8) begin errors++; $display("FAIL stall_br_count: got %0d want 8", br_count); end
      checks++; if (mispred_count !== 32'd7) begin errors++; $display("FAIL stall_mis_count: got %0d want 7", mispred_count); end
   endtask

   task automatic test_saturation();
      idle_e();
      force dut.br_count_q = 32'hFFFF_FFFE;
      force dut.mispred_count_q = 32'hFFFF_FFFE;
      #1;
      release dut.br_count_q;
      release dut.mispred_count_q;
      m_br = 64'hFFFF_FFFE; m_mis = 64'hFFFF_FFFE;
      for (int n = 0; n < 2; n++) begin
         set_e(1, 0, 1, 1, 32'h20, 32'h400, 0, 32'h0);
         step();
      end
      idle_e(); #1;
      checks++; if (br_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_br_count: got %h want ffffffff", br_count); end
      checks++; if (mispred_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_mis_count: got %h want ffffffff", mispred_count); end
   endtask

   task automatic test_random();
      logic [31:0] tg_pool [4];
      bit          exp_mis;
      tg_pool[0] = 32'h80; tg_pool[1] = 32'h300; tg_pool[2] = 32'h1000; tg_pool[3] = 32'hFFFF_FFF0;
      for (int n = 0; n < 400; n++) begin
         rst  = ($urandom_range(0, 99) < 2);
         pc_f = 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 31) << 2));
         valid_e    = ($urandom_range(0, 9) < 8);
         stall_e    = ($urandom_range(0, 9) < 2);
         is_br_e    = ($urandom_range(0, 9) < 8);
         br_taken_e = $urandom_range(0, 1);
         pc_e       = 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 31) << 2));
         br_target_e = tg_pool[$urandom_range(0, 3)];
         if ($urandom_range(0, 9) < 7) begin
            pred_taken_e  = m_pred(pc_e);
            pred_target_e = m_tgt[idx_of(pc_e)];
         end else begin
            pred_taken_e  = $urandom_range(0, 1);
            pred_target_e = tg_pool[$urandom_range(0, 3)];
         end
         #1;
         exp_mis = m_mispredict();
         checks++; if (pred_taken_f !== m_pred(pc_f)) begin errors++; $display("FAIL rnd_pred %0d: got %b want %b", n, pred_taken_f, m_pred(pc_f)); end
         if (m_pred(pc_f)) begin
            checks++; if (pred_target_f !== m_tgt[idx_of(pc_f)]) begin errors++; $display("FAIL rnd_tgt %0d: got %h want %h", n, pred_target_f, m_tgt[idx_of(pc_f)]); end
         end
         checks++; if (redirect_valid !== exp_mis) begin errors++; $display("FAIL rnd_redirect %0d: got %b want %b", n, redirect_valid, exp_mis); end
         checks++; if (flush_fd !== exp_mis) begin errors++; $display("FAIL rnd_flush %0d: got %b want %b", n, flush_fd, exp_mis); end
         if (exp_mis) begin
            checks++; if (redirect_pc !== m_rpc()) begin errors++; $display("FAIL rnd_rpc %0d: got %h want %h", n, redirect_pc, m_rpc()); end
         end
         checks++; if (br_count !== m_br[31:0]) begin errors++; $display("FAIL rnd_br_count %0d: got %h want %h", n, br_count, m_br[31:0]); end
         checks++; if (mispred_count !== m_mis[31:0]) begin errors++; $display("FAIL rnd_mis_count %0d: got %h want %h", n, mispred_count, m_mis[31:0]); end
         step();
      end
      rst = 1'b0; idle_e();
   endtask

   task automatic test_reset_mid();
      pc_f = 32'h40;
      set_e(1, 0, 1, 1, 32'h40, 32'h80, 1, 32'h80); step();
      set_e(1, 0, 1, 1, 32'h48, 32'h500, 0, 32'h0);
      rst = 1'b1; #1;
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL midrst_redirect: got %b want 0", redirect_valid); end
      checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL midrst_flush: got %b want 0", flush_fd); end
      step(); rst = 1'b0; idle_e(); #1;
      checks++; if (br_count !== 32'd0) begin errors++; $display("FAIL midrst_br_count: got %h want 0", br_count); end
      checks++; if (mispred_count !== 32'd0) begin errors++; $display("FAIL midrst_mis_count: got %h want 0", mispred_count); end
      for (int k = 0; k < DEPTH; k++) begin
         pc_f = 32'(k * 4); #1;
         checks++; if (pred_taken_f !== 1'b0) begin errors++; $display("FAIL midrst_pred idx %0d: got %b want 0", k, pred_taken_f); end
      end
   endtask

   initial begin
      model_reset();
      rst = 1'b1; pc_f = '0; idle_e();
      test_reset();
      test_train_and_redirect();
      test_alias();
      test_stall();
      test_saturation();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Sits between the fetch stage and execute-stage branch resolution in the 5-stage RV32I pipeline.
- Supplies fetch with a taken/not-taken prediction and target from a direct-mapped 2-bit-counter branch history table (BHT) and branch target buffer (BTB).
- Compares the prediction against the actual execute-stage outcome, then issues redirect and flush on a mispredict.
- Trains the tables and keeps saturating branch/mispredict statistics counters.

Parameters:
- IDX_W, 4, index width; table depth = 2**IDX_W entries, index = pc[IDX_W+1:2]
- XLEN, 32, address/data width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_f  in  XLEN  fetch-stage PC
- pred_taken_f  out  1  prediction for pc_f (combinational table read)
- pred_target_f  out  XLEN  predicted target for pc_f
- valid_e  in  1  execute stage holds a real (non-bubble) instruction
- stall_e  in  1  execute stage held this cycle; no resolution
- is_br_e  in  1  instruction in E is branch/JAL/JALR (opcode 1100011/1101111/1100111)
- br_taken_e  in  1  actual outcome from branch condition logic
- pc_e  in  XLEN  PC of instruction in E
- br_target_e  in  XLEN  computed actual target
- pred_taken_e  in  1  prediction carried down the pipe with this instruction
- pred_target_e  in  XLEN  predicted target carried down the pipe
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  XLEN  corrected next PC
- flush_fd  out  1  squash IF/ID and ID/EX registers
- br_count  out  32  resolved branches
- mispred_count  out  32  mispredicts

Behaviour:
- Reset (sync, rst=1 at edge):
  - all counters set to 2'b01 (weakly not taken), all BTB valid bits 0, targets 0.
  - br_count = mispred_count = 0.
  - While rst=1: redirect_valid = 0, flush_fd = 0.
  - Reset asserted mid-operation discards any pending update that cycle.
- Prediction (combinational, 0 latency):
  - i = pc_f[IDX_W+1:2]
  - pred_taken_f = valid[i] & ctr[i][1]
  - pred_target_f = tgt[i] (a don't-care value when pred_taken_f = 0)
- Resolution fires when res = valid_e & ~stall_e & ~rst.
  - actual_taken = is_br_e & br_taken_e
  - mispredict = res & ((actual_taken != pred_taken_e) | (actual_taken & pred_taken_e & (br_target_e != pred_target_e)))
  - A non-branch instruction that was predicted taken (aliasing) counts as a mispredict and redirects to pc_e+4.
- Redirect (combinational, same cycle as mispredict):
  - redirect_valid = flush_fd = mispredict.
  - redirect_pc = actual_taken ? br_target_e : pc_e + 4 (mod 2**XLEN, wraps at 0xFFFFFFFC -> 0).
- Training (registered, at the edge ending the resolve cycle), only when res & is_br_e; j = pc_e[IDX_W+1:2]:
  - ctr[j]: taken -> saturating increment (max 2'b11); not taken -> saturating decrement (min 2'b00).
  - If taken: tgt[j] <= br_target_e, valid[j] <= 1. If not taken: tgt/valid unchanged.
- Simultaneous fetch read and E write to the same index: fetch sees the pre-update (old) value; the new value is visible the next cycle.
- Stall: stall_e=1 blocks resolution, training, statistics and redirect, even if inputs indicate a mispredict.
- Statistics:
  - br_count += 1 on res & is_br_e.
  - mispred_count += 1 on mispredict.
  - Both saturate at 0xFFFFFFFF, no wrap.
- No internal FSM beyond the tables and counters. Each resolve is independent; back-to-back resolves in consecutive cycles are all honoured.

Test Plan:
- Reset, then pc_f=0x40 -> pred_taken_f=0. Resolve BEQ at pc_e=0x40, taken, target 0x80, pred_taken_e=0 -> redirect_valid=1, flush_fd=1, redirect_pc=0x80; next cycle ctr[0]=2'b10, pred_taken_f=1, pred_target_f=0x80; br_count=1, mispred_count=1.
- Same branch resolved taken 3 more times with correct prediction -> no redirect, ctr saturates at 2'b11. Then not taken with pred_taken_e=1 -> redirect_pc=0x44, ctr=2'b10, prediction still taken.
- JALR at pc_e=0x100, predicted taken to 0x200, actual target 0x300 -> mispredict, redirect_pc=0x300, tgt[0] updated to 0x300.
- Non-branch (is_br_e=0) at 0x10 with pred_taken_e=1 -> redirect_pc=0x14, table unchanged, br_count unchanged, mispred_count +1.
- Mispredicting branch with stall_e=1 for 2 cycles, then stall_e=0 -> redirect only in the unstalled cycle, counters increment exactly once. Same-index fetch in the update cycle returns the old prediction.
- Preload mispred_count to 0xFFFFFFFF via repeated mispredicts (or a forced value), one more mispredict -> stays 0xFFFFFFFF. Assert rst mid-stream -> all counters 0, all predictions not taken next cycle.
